// File: rtl/serial_subtractor16_if.sv
// Request/result bundle between a controller and the bit-serial subtractor.
// The controller drives start/A/B and watches busy/done/Diff/Borrow.
// The subtractor uses the slave modport; the controller or bench uses master.
interface serial_subtractor16_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Diff;
  logic         Borrow;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Borrow
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Borrow
  );
endinterface

// File: rtl/serial_subtractor16.sv
// Bit-serial N-bit subtractor: Diff = A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: start accepted at edge k, result and one-cycle done at edge k+N; busy high in between.
// Backpressure: start is only sampled while idle; starts during a run are dropped, so one result per N+1 cycles max.
module serial_subtractor16 #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor16_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sd;
  logic [N-1:0]   sd_nxt;
  logic [N-1:0]   diff_q;
  logic           borrow_q;
  logic           done_q;
  logic           br;
  logic           br_nxt;
  logic           d;
  logic           last;
  logic [CW-1:0]  cnt;

  // Full-subtractor cell on the current LSBs; the new bit enters the result at the MSB.
  always_comb begin
    d      = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sd_nxt = {d, sd[N-1:1]};
    last   = (cnt == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: idle until a start is seen, run until the last bit is processed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (last)      state_nxt = IDLE;
    endcase
  end

  // Outputs: busy mirrors RUN; result and done come straight from their flops.
  always_comb begin
    bus.busy   = (state == RUN);
    bus.done   = done_q;
    bus.Diff   = diff_q;
    bus.Borrow = borrow_q;
  end

  // Datapath: capture operands on accept, shift one bit per RUN edge, publish the result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sd       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          sa  <= bus.A;
          sb  <= bus.B;
          br  <= 1'b0;
          cnt <= '0;
        end
      end else begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sd  <= sd_nxt;
        br  <= br_nxt;
        cnt <= cnt + CW'(1);
        if (last) begin
          diff_q   <= sd_nxt;
          borrow_q <= br_nxt;
          done_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed bench for serial_subtractor16: reset state, arithmetic vectors, timing,
// back-to-back acceptance, starts ignored while busy, and asynchronous abort.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_subtractor16;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  serial_subtractor16_if #(.N(16)) bus ();

  serial_subtractor16 #(.N(16), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done. lat counts falling edges after the
  // accept edge until done is seen (16 expected); bcnt counts busy samples meanwhile.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat, output int bcnt);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.Diff, bus.Borrow} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b Diff=%h Borrow=%b, want all 0",
               bus.busy, bus.done, bus.Diff, bus.Borrow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    do_op(16'd5, 16'd3, lat, bcnt);
    tests_run++;
    if (lat !== 16) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, want 16", lat);
    end
    tests_run++;
    if (bcnt !== 16) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d, want 16", bcnt);
    end
    tests_run++;
    if (bus.Diff !== 16'h0002 || bus.Borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got %h/%b, want 0002/0", bus.Diff, bus.Borrow);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.Diff !== 16'h0002) begin
      tests_failed++;
      $display("FAIL basic_done_width: done=%b Diff=%h, want done=0 Diff=0002", bus.done, bus.Diff);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vd [4];
    logic        vw [4];
    int lat, bcnt;
    va[0] = 16'h0003; vb[0] = 16'h0005; vd[0] = 16'hFFFE; vw[0] = 1'b1;
    va[1] = 16'h0000; vb[1] = 16'h0000; vd[1] = 16'h0000; vw[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h0001; vd[2] = 16'h7FFF; vw[2] = 1'b0;
    va[3] = 16'h0000; vb[3] = 16'hFFFF; vd[3] = 16'h0001; vw[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], lat, bcnt);
      tests_run++;
      if (lat !== 16 || bus.Diff !== vd[i] || bus.Borrow !== vw[i]) begin
        tests_failed++;
        $display("FAIL vector_%0d (%h-%h): got %h/%b lat %0d, want %h/%b lat 16",
                 i, va[i], vb[i], bus.Diff, bus.Borrow, lat, vd[i], vw[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int j, p;
    @(negedge clk);
    bus.A = 16'd10;
    bus.B = 16'd4;
    bus.start = 1'b1;
    @(negedge clk);
    j = 0;
    while (bus.done !== 1'b1 && j < 40) begin
      if (j == 5) begin
        bus.A = 16'd1;
        bus.B = 16'd2;
      end
      @(negedge clk);
      j++;
    end
    tests_run++;
    if (j !== 16 || bus.Diff !== 16'h0006 || bus.Borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h/%b lat %0d, want 0006/0 lat 16", bus.Diff, bus.Borrow, j);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept_in_done_cycle: busy=%b, want 1", bus.busy);
    end
    p = 1;
    while (bus.done !== 1'b1 && p < 60) begin
      @(negedge clk);
      p++;
    end
    tests_run++;
    if (p !== 17) begin
      tests_failed++;
      $display("FAIL b2b_period: got %0d, want 17", p);
    end
    tests_run++;
    if (bus.Diff !== 16'hFFFF || bus.Borrow !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h/%b, want FFFF/1", bus.Diff, bus.Borrow);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int ndone, first;
    @(negedge clk);
    bus.A = 16'd1;
    bus.B = 16'd100;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    first = -1;
    for (int j = 0; j < 50; j++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first < 0) first = j;
      end
      if (j == 8) begin
        tests_run++;
        if (bus.Diff !== 16'hFFFF || bus.Borrow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ignore_hold_prev: got %h/%b, want FFFF/1", bus.Diff, bus.Borrow);
        end
      end
      if (j == 16) begin
        tests_run++;
        if (bus.Diff !== 16'hFF9D || bus.Borrow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ignore_result: got %h/%b, want FF9D/1", bus.Diff, bus.Borrow);
        end
      end
      bus.start = (j == 5);
      if (j == 5) begin
        bus.A = 16'hFFFF;
        bus.B = 16'h0000;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    tests_run++;
    if (ndone !== 1 || first !== 16) begin
      tests_failed++;
      $display("FAIL ignore_done_count: got %0d pulses first at %0d, want 1 at 16", ndone, first);
    end
  endtask

  task automatic test_async_reset();
    int ndone, lat, bcnt;
    @(negedge clk);
    bus.A = 16'h1234;
    bus.B = 16'h0034;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_busy_before: busy=%b, want 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.Diff, bus.Borrow} !== 19'h0) begin
      tests_failed++;
      $display("FAIL abort_async_clear: busy=%b done=%b Diff=%h Borrow=%b, want all 0",
               bus.busy, bus.done, bus.Diff, bus.Borrow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone !== 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d pulses busy=%b, want 0 pulses busy=0", ndone, bus.busy);
    end
    do_op(16'd7, 16'd7, lat, bcnt);
    tests_run++;
    if (lat !== 16 || bus.Diff !== 16'h0000 || bus.Borrow !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_fresh_op: got %h/%b lat %0d, want 0000/0 lat 16", bus.Diff, bus.Borrow, lat);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_busy_ignore();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
